qam_slicer: RTL and testbench
=============================

QAM_SLICER -- requirements
Module: qam_slicer

Interface
REQ-001 SHALL have parameter W, default 16: width of i_y_re/i_y_im and of reconstructed symbols.
REQ-002 SHALL have parameter STEP_LOG2, default 12: level half-spacing STEP = 1<<STEP_LOG2; constellation levels per axis are odd multiples of STEP.
REQ-003 SHALL have ports: clk in 1 clock; rst in 1 reset, synchronous, active-high.
REQ-004 SHALL have ports: i_valid in 1, o_ready out 1: upstream handshake, beat accepted when both are high.
REQ-005 SHALL have ports: i_first in 1, i_last in 1: frame delimiters of the input beat.
REQ-006 SHALL have ports: i_mode in 2: constellation select, 0 QPSK, 1 16-QAM, 2 64-QAM, 3 reserved.
REQ-007 SHALL have ports: i_y_re, i_y_im in W signed: equalised symbol.
REQ-008 SHALL have ports: o_valid out 1, i_ready in 1: downstream handshake.
REQ-009 SHALL have ports: o_first, o_last out 1: delimiters aligned with the output beat.
REQ-010 SHALL have ports: o_bI, o_bQ out 3: Gray-coded decided bits, LSB-aligned, unused MSBs zero.
REQ-011 SHALL have ports: o_yhat_re, o_yhat_im out W signed: reconstructed decided symbol.
REQ-012 SHALL have ports: o_sym_cnt out 16: index of the output beat within its frame; o_proto_err out 1: sticky framing error.

Function
REQ-013 SHALL derive L per axis: 2 for QPSK or reserved mode, 4 for 16-QAM, 8 for 64-QAM.
REQ-014 SHALL compute idx = clamp(floor((y + L*STEP) / (2*STEP)), 0, L-1) in W+2-bit arithmetic, with no overflow for any W-bit input.
REQ-015 SHALL resolve ties: y on a decision boundary SHALL decide the upper level, e.g. y=0 in QPSK gives a positive decision.
REQ-016 SHALL reconstruct yhat = (2*idx - L + 1)*STEP.
REQ-017 SHALL output bits = Gray(L-1-idx); in QPSK a negative axis gives bit 1.
REQ-018 SHALL use a 2-stage pipeline: latency 2 cycles from acceptance to o_valid while i_ready stays high, throughput 1 beat per cycle.
REQ-019 SHALL assert o_ready unless both stages are full and i_ready is low; while o_valid is high and i_ready is low, all outputs SHALL hold stable and no beat SHALL be lost or duplicated.
REQ-020 SHALL run frame FSM IDLE/IN_FRAME: accepted i_first moves to IN_FRAME and latches i_mode for the whole frame; accepted i_last returns to IDLE; i_first together with i_last is a one-beat frame.
REQ-021 SHALL ignore i_mode on beats without i_first.
REQ-022 SHALL handle framing errors: i_first accepted while IN_FRAME sets o_proto_err and restarts the frame with the new mode; a beat without i_first accepted in IDLE sets o_proto_err and is processed with the last latched mode.
REQ-023 SHALL restart o_sym_cnt at 0 on o_first and saturate it at 16'hFFFF.

Reset
REQ-024 SHALL clear on rst, which has priority over any handshake: o_valid, o_first, o_last, o_bI, o_bQ, o_yhat_re, o_yhat_im, o_sym_cnt and o_proto_err to 0, both pipeline stages emptied, FSM to IDLE, latched mode to QPSK; o_ready SHALL be 1 in the cycle after rst deasserts.
REQ-025 SHALL discard in-flight beats when rst is asserted mid-frame.

Configuration
REQ-026 SHALL, with QAM_SLICER_ERR_EN defined, add outputs o_err_re, o_err_im (W+1 signed) = y - yhat, aligned with and stalled like o_yhat, for LMS update.
REQ-027 SHALL, with QAM_SLICER_ERR_EN undefined, omit these ports and their logic.

Structure
REQ-028 SHALL place in package qam_slicer_pkg: the mode enum (MODE_QPSK, MODE_16QAM, MODE_64QAM), MAX_BITS=3, the levels-per-mode function and the Gray-encode function.
REQ-029 SHALL implement per-axis decision as sub-module qam_axis_dec (y, L -> idx, bits, yhat), instantiated for I and Q.

Verification
REQ-030 SHALL pass: QPSK, y=(5000,-1), i_ready=1 -> 2 cycles later yhat=(4096,-4096), bI=0, bQ=1.
REQ-031 SHALL pass: 16-QAM, y=(8192,-32768) -> yhat=(12288,-12288), idx I=3 (tie goes up), idx Q=0 (clamped).
REQ-032 SHALL pass: 64-QAM, y=32767 -> yhat=28672; with QAM_SLICER_ERR_EN, err=4095.
REQ-033 SHALL pass: a 10-beat stream with i_ready toggled 1/0 every cycle -> all 10 beats out in order, outputs stable during stalls, o_sym_cnt 0..9.
REQ-034 SHALL pass: i_mode changed mid-frame -> ignored; a second i_first before i_last -> o_proto_err=1 and o_sym_cnt restarts.
REQ-035 SHALL pass: rst asserted with 2 beats in flight -> o_valid=0 the next cycle, no stale beat emitted afterwards.

Source files
------------

// File: rtl/qam_slicer_pkg.sv
// Shared types and helpers for the QAM slicer.
// Contents: constellation mode encoding, MAX_BITS (decided bits per axis),
// levels-per-axis lookup and a binary-to-Gray encoder.
package qam_slicer_pkg;

  typedef enum logic [1:0] {
    MODE_QPSK  = 2'd0,
    MODE_16QAM = 2'd1,
    MODE_64QAM = 2'd2
  } mode_e;

  localparam int unsigned MAX_BITS = 3;

  // Levels per axis; the reserved encoding (3) falls back to QPSK.
  function automatic logic [3:0] mode_levels(input logic [1:0] mode);
    logic [3:0] lvl;
    case (mode)
      MODE_16QAM: lvl = 4'd4;
      MODE_64QAM: lvl = 4'd8;
      default:    lvl = 4'd2;
    endcase
    return lvl;
  endfunction

  function automatic logic [MAX_BITS-1:0] gray_enc(input logic [MAX_BITS-1:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/qam_slicer_if.sv
// Stream bundle between the slicer and its neighbours.
// Upstream:   i_valid/o_ready handshake, i_first/i_last, i_mode, i_y_re/i_y_im.
// Downstream: o_valid/i_ready handshake, o_first/o_last, o_bI/o_bQ, o_yhat_re/o_yhat_im,
//             o_sym_cnt, o_proto_err, and o_err_re/o_err_im when QAM_SLICER_ERR_EN is defined.
// Modports: slave = slicer side, master = the environment driving and consuming it.
interface qam_slicer_if #(
  parameter int unsigned W = 16
);
  logic                i_valid;
  logic                o_ready;
  logic                i_first;
  logic                i_last;
  logic [1:0]          i_mode;
  logic signed [W-1:0] i_y_re;
  logic signed [W-1:0] i_y_im;

  logic                o_valid;
  logic                i_ready;
  logic                o_first;
  logic                o_last;
  logic [2:0]          o_bI;
  logic [2:0]          o_bQ;
  logic signed [W-1:0] o_yhat_re;
  logic signed [W-1:0] o_yhat_im;
  logic [15:0]         o_sym_cnt;
  logic                o_proto_err;
`ifdef QAM_SLICER_ERR_EN
  logic signed [W:0]   o_err_re;
  logic signed [W:0]   o_err_im;
`endif

  modport slave (
    input  i_valid, i_first, i_last, i_mode, i_y_re, i_y_im, i_ready,
    output o_ready, o_valid, o_first, o_last, o_bI, o_bQ, o_yhat_re, o_yhat_im,
    output o_sym_cnt, o_proto_err
`ifdef QAM_SLICER_ERR_EN
    , output o_err_re, o_err_im
`endif
  );

  modport master (
    output i_valid, i_first, i_last, i_mode, i_y_re, i_y_im, i_ready,
    input  o_ready, o_valid, o_first, o_last, o_bI, o_bQ, o_yhat_re, o_yhat_im,
    input  o_sym_cnt, o_proto_err
`ifdef QAM_SLICER_ERR_EN
    , input o_err_re, o_err_im
`endif
  );

endinterface

// File: rtl/qam_axis_dec.sv
// Single-axis hard decision for a square QAM constellation.
// Ports: y_i (signed sample), lvl_i (levels on this axis: 2, 4 or 8)
//        -> idx_o (level index, 0 = most negative), bits_o (Gray bits, LSB-aligned),
//           yhat_o (reconstructed level, odd multiple of 1<<STEP_LOG2).
// Purely combinational.
module qam_axis_dec
  import qam_slicer_pkg::*;
#(
  parameter int unsigned W         = 16,
  parameter int unsigned STEP_LOG2 = 12
) (
  input  logic signed [W-1:0]        y_i,
  input  logic [3:0]                 lvl_i,
  output logic [MAX_BITS-1:0]        idx_o,
  output logic [MAX_BITS-1:0]        bits_o,
  output logic signed [W-1:0]        yhat_o
);

  // Two guard bits so y + L*STEP cannot overflow for any W-bit y.
  localparam int unsigned XW = W + 2;

  logic signed [XW-1:0] y_x;
  logic signed [XW-1:0] lvl_x;
  logic signed [XW-1:0] lvl_m1;
  logic signed [XW-1:0] sum;
  logic signed [XW-1:0] q;
  logic [MAX_BITS-1:0]  idx;
  logic signed [4:0]    level;

  always_comb begin
    y_x    = {{2{y_i[W-1]}}, y_i};
    lvl_x  = {{(XW-4){1'b0}}, lvl_i};
    lvl_m1 = lvl_x - 1;
    sum    = y_x + (lvl_x <<< STEP_LOG2);
    // Arithmetic shift is floor division, so a sample on a boundary lands on the upper level.
    q      = sum >>> (STEP_LOG2 + 1);

    if (q < 0) begin
      idx = '0;
    end else if (q > lvl_m1) begin
      idx = lvl_m1[MAX_BITS-1:0];
    end else begin
      idx = q[MAX_BITS-1:0];
    end

    // Signed level number 2*idx - L + 1, in -7..7.
    level  = $signed({1'b0, idx, 1'b0}) - $signed({1'b0, lvl_i}) + 5'sd1;
    yhat_o = {{(W-5){level[4]}}, level} <<< STEP_LOG2;
    // Highest level maps to all-zero bits.
    bits_o = gray_enc(lvl_m1[MAX_BITS-1:0] - idx);
    idx_o  = idx;
  end

endmodule

// File: rtl/qam_slicer.sv
// QAM hard-decision slicer with frame tracking.
// Ports: clk, rst (synchronous, active-high), bus (qam_slicer_if.slave): equalised symbols
//        in with frame delimiters and mode, decided Gray bits, reconstructed symbol,
//        in-frame symbol index and a sticky framing-error flag out.
// Pipeline: stage 1 registers the accepted beat with its resolved level count, stage 2
// registers the decision; latency 2 cycles, one beat per cycle, full backpressure.
// Option: define QAM_SLICER_ERR_EN to add o_err_re/o_err_im = y - yhat (for LMS).
module qam_slicer
  import qam_slicer_pkg::*;
#(
  parameter int unsigned W         = 16,
  parameter int unsigned STEP_LOG2 = 12
) (
  input logic         clk,
  input logic         rst,
  qam_slicer_if.slave bus
);

  localparam logic [0:0] ST_IDLE     = 1'b0;
  localparam logic [0:0] ST_IN_FRAME = 1'b1;

  logic [0:0] state_q, state_d;
  logic [1:0] mode_q, mode_d;
  logic       proto_err_q, proto_err_d;

  logic                s1_valid_q, s1_valid_d;
  logic                s1_first_q, s1_first_d;
  logic                s1_last_q, s1_last_d;
  logic signed [W-1:0] s1_re_q, s1_re_d;
  logic signed [W-1:0] s1_im_q, s1_im_d;
  logic [3:0]          s1_lvl_q, s1_lvl_d;

  logic                s2_valid_q, s2_valid_d;
  logic                s2_first_q, s2_first_d;
  logic                s2_last_q, s2_last_d;
  logic [2:0]          s2_bi_q, s2_bi_d;
  logic [2:0]          s2_bq_q, s2_bq_d;
  logic signed [W-1:0] s2_yhat_re_q, s2_yhat_re_d;
  logic signed [W-1:0] s2_yhat_im_q, s2_yhat_im_d;
  logic [15:0]         sym_cnt_q, sym_cnt_d;
`ifdef QAM_SLICER_ERR_EN
  logic signed [W:0]   s2_err_re_q, s2_err_re_d;
  logic signed [W:0]   s2_err_im_q, s2_err_im_d;
`endif

  logic                s1_en, s2_en, accept;
  logic [1:0]          beat_mode;
  logic [2:0]          idx_re, idx_im, bits_re, bits_im;
  logic signed [W-1:0] yhat_re, yhat_im;

  qam_axis_dec #(.W(W), .STEP_LOG2(STEP_LOG2)) u_dec_re (
    .y_i    (s1_re_q),
    .lvl_i  (s1_lvl_q),
    .idx_o  (idx_re),
    .bits_o (bits_re),
    .yhat_o (yhat_re)
  );

  qam_axis_dec #(.W(W), .STEP_LOG2(STEP_LOG2)) u_dec_im (
    .y_i    (s1_im_q),
    .lvl_i  (s1_lvl_q),
    .idx_o  (idx_im),
    .bits_o (bits_im),
    .yhat_o (yhat_im)
  );

  // Each stage advances when empty or when the stage after it moves.
  assign s2_en  = !s2_valid_q || bus.i_ready;
  assign s1_en  = !s1_valid_q || s2_en;
  assign accept = bus.i_valid && s1_en;
  // Mode is sampled only on a frame start; other beats use the latched one.
  assign beat_mode = bus.i_first ? bus.i_mode : mode_q;

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    proto_err_d = proto_err_q;
    if (accept) begin
      if (bus.i_first) begin
        if (state_q == ST_IN_FRAME) proto_err_d = 1'b1;
        mode_d = bus.i_mode;
      end else if (state_q == ST_IDLE) begin
        proto_err_d = 1'b1;
      end
      if (bus.i_last) begin
        state_d = ST_IDLE;
      end else if (bus.i_first) begin
        state_d = ST_IN_FRAME;
      end
    end
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_first_d = s1_first_q;
    s1_last_d  = s1_last_q;
    s1_re_d    = s1_re_q;
    s1_im_d    = s1_im_q;
    s1_lvl_d   = s1_lvl_q;
    if (s1_en) begin
      s1_valid_d = accept;
      if (accept) begin
        s1_first_d = bus.i_first;
        s1_last_d  = bus.i_last;
        s1_re_d    = bus.i_y_re;
        s1_im_d    = bus.i_y_im;
        s1_lvl_d   = mode_levels(beat_mode);
      end
    end
  end

  always_comb begin
    s2_valid_d   = s2_valid_q;
    s2_first_d   = s2_first_q;
    s2_last_d    = s2_last_q;
    s2_bi_d      = s2_bi_q;
    s2_bq_d      = s2_bq_q;
    s2_yhat_re_d = s2_yhat_re_q;
    s2_yhat_im_d = s2_yhat_im_q;
    sym_cnt_d    = sym_cnt_q;
`ifdef QAM_SLICER_ERR_EN
    s2_err_re_d  = s2_err_re_q;
    s2_err_im_d  = s2_err_im_q;
`endif
    if (s2_en) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_first_d   = s1_first_q;
        s2_last_d    = s1_last_q;
        s2_bi_d      = bits_re;
        s2_bq_d      = bits_im;
        s2_yhat_re_d = yhat_re;
        s2_yhat_im_d = yhat_im;
        if (s1_first_q) begin
          sym_cnt_d = '0;
        end else if (sym_cnt_q != 16'hFFFF) begin
          sym_cnt_d = sym_cnt_q + 16'd1;
        end
`ifdef QAM_SLICER_ERR_EN
        s2_err_re_d = {s1_re_q[W-1], s1_re_q} - {yhat_re[W-1], yhat_re};
        s2_err_im_d = {s1_im_q[W-1], s1_im_q} - {yhat_im[W-1], yhat_im};
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      mode_q       <= MODE_QPSK;
      proto_err_q  <= 1'b0;
      s1_valid_q   <= 1'b0;
      s1_first_q   <= 1'b0;
      s1_last_q    <= 1'b0;
      s1_re_q      <= '0;
      s1_im_q      <= '0;
      s1_lvl_q     <= 4'd2;
      s2_valid_q   <= 1'b0;
      s2_first_q   <= 1'b0;
      s2_last_q    <= 1'b0;
      s2_bi_q      <= '0;
      s2_bq_q      <= '0;
      s2_yhat_re_q <= '0;
      s2_yhat_im_q <= '0;
      sym_cnt_q    <= '0;
`ifdef QAM_SLICER_ERR_EN
      s2_err_re_q  <= '0;
      s2_err_im_q  <= '0;
`endif
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      proto_err_q  <= proto_err_d;
      s1_valid_q   <= s1_valid_d;
      s1_first_q   <= s1_first_d;
      s1_last_q    <= s1_last_d;
      s1_re_q      <= s1_re_d;
      s1_im_q      <= s1_im_d;
      s1_lvl_q     <= s1_lvl_d;
      s2_valid_q   <= s2_valid_d;
      s2_first_q   <= s2_first_d;
      s2_last_q    <= s2_last_d;
      s2_bi_q      <= s2_bi_d;
      s2_bq_q      <= s2_bq_d;
      s2_yhat_re_q <= s2_yhat_re_d;
      s2_yhat_im_q <= s2_yhat_im_d;
      sym_cnt_q    <= sym_cnt_d;
`ifdef QAM_SLICER_ERR_EN
      s2_err_re_q  <= s2_err_re_d;
      s2_err_im_q  <= s2_err_im_d;
`endif
    end
  end

  // A decided index must always be one of the L levels.
  idx_in_range_a: assert property (@(posedge clk) disable iff (rst)
    s1_valid_q |-> (({1'b0, idx_re} < s1_lvl_q) && ({1'b0, idx_im} < s1_lvl_q)));

  assign bus.o_ready     = s1_en;
  assign bus.o_valid     = s2_valid_q;
  assign bus.o_first     = s2_first_q;
  assign bus.o_last      = s2_last_q;
  assign bus.o_bI        = s2_bi_q;
  assign bus.o_bQ        = s2_bq_q;
  assign bus.o_yhat_re   = s2_yhat_re_q;
  assign bus.o_yhat_im   = s2_yhat_im_q;
  assign bus.o_sym_cnt   = sym_cnt_q;
  assign bus.o_proto_err = proto_err_q;
`ifdef QAM_SLICER_ERR_EN
  assign bus.o_err_re    = s2_err_re_q;
  assign bus.o_err_im    = s2_err_im_q;
`endif

endmodule

// File: tb/tb_qam_slicer.sv
// Directed testbench for qam_slicer (W=16, STEP=4096) with hand-computed expectations.
module tb_qam_slicer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  qam_slicer_if #(.W(16)) bus ();

  qam_slicer #(.W(16), .STEP_LOG2(12)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic       first;
    logic       last;
    logic [2:0] bi;
    logic [2:0] bq;
    int         re;
    int         im;
    int         cnt;  // -1: not checked
    int         er;
    int         ei;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_mis = 0;
  int   rdy_pat = 0;  // 0: ready high, 1: toggle each cycle, 2: ready low

  // 16-QAM per-axis results by index.
  int lvl16[4]  = '{-12288, -4096, 4096, 12288};
  int gray16[4] = '{2, 3, 1, 0};

  // 10-beat 16-QAM stream with hand-derived level indices.
  int t4_re[10] = '{-20000, -8192, -1, 0, 8191, 8192, 30000, -16384, -16385, 100};
  int t4_im[10] = '{100, -16385, -16384, 30000, 8192, 8191, 0, -1, -8192, -20000};
  int t4_ir[10] = '{0, 1, 1, 2, 2, 3, 3, 0, 0, 2};
  int t4_iq[10] = '{2, 0, 0, 3, 3, 2, 2, 1, 1, 0};

  task automatic check_val(input string tag, input longint got, input longint exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic void exp_push(input logic first, input logic last, input logic [2:0] bi,
                                   input logic [2:0] bq, input int re, input int im,
                                   input int cnt, input int er, input int ei);
    exp_t e;
    e.first = first; e.last = last; e.bi = bi; e.bq = bq;
    e.re = re; e.im = im; e.cnt = cnt; e.er = er; e.ei = ei;
    exp_q.push_back(e);
  endfunction

  task automatic align();
    @(posedge clk);
    #1;
  endtask

  // Call at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic first, input logic last, input logic [1:0] mode,
                      input int re, input int im);
    logic ok;
    ok = 1'b0;
    bus.i_valid = 1'b1;
    bus.i_first = first;
    bus.i_last  = last;
    bus.i_mode  = mode;
    bus.i_y_re  = 16'(re);
    bus.i_y_im  = 16'(im);
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (bus.o_ready) begin
        ok = 1'b1;
        break;
      end
    end
    check_val("accept", longint'(ok), 1);
    @(posedge clk);
    #1;
    bus.i_valid = 1'b0;
    bus.i_first = 1'b0;
    bus.i_last  = 1'b0;
  endtask

  task automatic wait_drain();
    for (int n = 0; n < 200 && exp_q.size() != 0; n++) @(negedge clk);
    @(negedge clk);
    check_val("drain", longint'(exp_q.size()), 0);
  endtask

  // Downstream ready driver.
  initial begin
    bus.i_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_pat)
        1:       bus.i_ready = ~bus.i_ready;
        2:       bus.i_ready = 1'b0;
        default: bus.i_ready = 1'b1;
      endcase
    end
  end

  // Output monitor: scoreboard on each transfer, hold check across stalls.
  initial begin
    logic        prev_stall;
    logic [56:0] snap, prev_snap;
    exp_t        e;
    prev_stall = 1'b0;
    prev_snap  = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
        continue;
      end
      snap = {bus.o_valid, bus.o_first, bus.o_last, bus.o_bI, bus.o_bQ,
              bus.o_yhat_re, bus.o_yhat_im, bus.o_sym_cnt};
      if (prev_stall) check_val("stall_hold", longint'(snap), longint'(prev_snap));
      if (bus.o_valid && bus.i_ready) begin
        check_val("beat_expected", longint'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check_val("o_first", longint'(bus.o_first), longint'(e.first));
          check_val("o_last", longint'(bus.o_last), longint'(e.last));
          check_val("o_bI", longint'(bus.o_bI), longint'(e.bi));
          check_val("o_bQ", longint'(bus.o_bQ), longint'(e.bq));
          check_val("yhat_re", bus.o_yhat_re, e.re);
          check_val("yhat_im", bus.o_yhat_im, e.im);
          if (e.cnt >= 0) check_val("sym_cnt", longint'(bus.o_sym_cnt), e.cnt);
`ifdef QAM_SLICER_ERR_EN
          check_val("err_re", bus.o_err_re, e.er);
          check_val("err_im", bus.o_err_im, e.ei);
`endif
        end
      end
      prev_stall = bus.o_valid && !bus.i_ready;
      prev_snap  = snap;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.i_valid = 1'b0;
    bus.i_first = 1'b0;
    bus.i_last  = 1'b0;
    bus.i_mode  = 2'd0;
    bus.i_y_re  = '0;
    bus.i_y_im  = '0;

    // Reset state.
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("rst_o_valid", longint'(bus.o_valid), 0);
    check_val("rst_proto_err", longint'(bus.o_proto_err), 0);
    check_val("rst_sym_cnt", longint'(bus.o_sym_cnt), 0);
    check_val("rst_yhat_re", bus.o_yhat_re, 0);
    check_val("rst_bits", longint'({bus.o_bI, bus.o_bQ}), 0);
    align();
    rst = 1'b0;
    @(negedge clk);
    check_val("rst_o_ready", longint'(bus.o_ready), 1);
    align();

    // QPSK, latency 2, y=(5000,-1): tie-free, Q negative gives bit 1.
    exp_push(1, 1, 3'd0, 3'd1, 4096, -4096, 0, 904, 4095);
    send(1, 1, 2'd0, 5000, -1);
    @(negedge clk);
    check_val("latency_c1", longint'(bus.o_valid), 0);
    @(negedge clk);
    check_val("latency_c2", longint'(bus.o_valid), 1);
    wait_drain();
    align();

    // 16-QAM: I on a boundary goes up, Q clamps to the lowest level.
    exp_push(1, 1, 3'd0, 3'd2, 12288, -12288, 0, -4096, -20480);
    send(1, 1, 2'd1, 8192, -32768);
    wait_drain();
    align();

    // 64-QAM: full-scale inputs clamp to the outer levels; then y=-1 and y=0.
    exp_push(1, 0, 3'd0, 3'd4, 28672, -28672, 0, 4095, -4096);
    exp_push(0, 1, 3'd6, 3'd2, -4096, 4096, 1, 4095, -4096);
    send(1, 0, 2'd2, 32767, -32768);
    send(0, 1, 2'd2, -1, 0);
    wait_drain();
    align();

    // 10 beats, ready toggling, later beats carry a different (ignored) mode.
    rdy_pat = 1;
    for (int k = 0; k < 10; k++) begin
      exp_push(k == 0, k == 9, 3'(gray16[t4_ir[k]]), 3'(gray16[t4_iq[k]]),
               lvl16[t4_ir[k]], lvl16[t4_iq[k]], k,
               t4_re[k] - lvl16[t4_ir[k]], t4_im[k] - lvl16[t4_iq[k]]);
    end
    for (int k = 0; k < 10; k++) begin
      send(k == 0, k == 9, (k == 0) ? 2'd1 : 2'd2, t4_re[k], t4_im[k]);
    end
    wait_drain();
    check_val("no_err_yet", longint'(bus.o_proto_err), 0);
    rdy_pat = 0;
    align();

    // Mid-frame mode change ignored; second i_first restarts the frame in 16-QAM.
    exp_push(1, 0, 3'd0, 3'd0, 4096, 4096, 0, -3096, -3096);
    exp_push(0, 0, 3'd1, 3'd0, -4096, 4096, 1, 3096, -3096);
    exp_push(1, 0, 3'd1, 3'd1, 4096, 4096, 0, -4096, -4096);
    exp_push(0, 1, 3'd3, 3'd0, -4096, 12288, 1, -4096, -4096);
    send(1, 0, 2'd0, 1000, 1000);
    send(0, 0, 2'd2, -1000, 1000);
    send(1, 0, 2'd1, 0, 0);
    send(0, 1, 2'd0, -8192, 8192);
    wait_drain();
    check_val("restart_proto_err", longint'(bus.o_proto_err), 1);
    align();

    // Reset with two beats held in the pipeline.
    rdy_pat = 2;
    repeat (2) align();
    send(1, 0, 2'd1, 4000, 4000);
    send(0, 0, 2'd1, -4000, -4000);
    @(negedge clk);
    check_val("inflight_valid", longint'(bus.o_valid), 1);
    align();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_val("midrst_o_valid", longint'(bus.o_valid), 0);
    check_val("midrst_proto_err", longint'(bus.o_proto_err), 0);
    check_val("midrst_sym_cnt", longint'(bus.o_sym_cnt), 0);
    check_val("midrst_yhat_im", bus.o_yhat_im, 0);
    align();
    rst = 1'b0;
    rdy_pat = 0;
    @(negedge clk);
    check_val("midrst_o_ready", longint'(bus.o_ready), 1);
    repeat (10) @(negedge clk);
    check_val("no_stale_beat", longint'(bus.o_valid), 0);
    align();

    // Beat without i_first in IDLE: flagged, sliced with the reset mode (QPSK).
    exp_push(0, 1, 3'd1, 3'd0, -4096, 4096, -1, 4091, -4091);
    send(0, 1, 2'd2, -5, 5);
    wait_drain();
    check_val("idle_proto_err", longint'(bus.o_proto_err), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
